// File: rtl/frv_ex_wb_buffer.sv
// frv_ex_wb_buffer: two-entry skid buffer between execute and writeback.
// Ports:
//   g_clk, g_resetn (sync, active low), flush
//   ex_valid/ex_ready/ex_result/ex_rd/ex_wen : execute-side handshake
//   wb_valid/wb_ready/wb_result/wb_rd/wb_wen : writeback-side head entry
//   hz_rs1/2, hz_rs1/2_hit, hz_rs1/2_data   : forwarding lookup,
//   present only when FRV_EX_WB_FWD_EN is defined.
module frv_ex_wb_buffer #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            flush,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_result,
    input  logic [RD_W-1:0] ex_rd,
    input  logic            ex_wen,
`ifdef FRV_EX_WB_FWD_EN
    input  logic [RD_W-1:0] hz_rs1,
    input  logic [RD_W-1:0] hz_rs2,
    output logic            hz_rs1_hit,
    output logic            hz_rs2_hit,
    output logic [XLEN-1:0] hz_rs1_data,
    output logic [XLEN-1:0] hz_rs2_data,
`endif
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_result,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_wen
);

    localparam int XL = XLEN - 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XL:0]     e0_res_q, e0_res_d;
    logic [RD_W-1:0] e0_rd_q, e0_rd_d;
    logic            e0_wen_q, e0_wen_d;
    logic [XL:0]     e1_res_q, e1_res_d;
    logic [RD_W-1:0] e1_rd_q, e1_rd_d;
    logic            e1_wen_q, e1_wen_d;

    logic push, pop;

    // Handshake flags come only from state, never from wb_ready.
    assign ex_ready  = (state_q != FULL);
    assign wb_valid  = (state_q != EMPTY);
    assign wb_result = e0_res_q;
    assign wb_rd     = e0_rd_q;
    assign wb_wen    = e0_wen_q;

    assign push = ex_valid & ex_ready;
    assign pop  = wb_valid & wb_ready;

    always_comb begin
        state_d  = state_q;
        e0_res_d = e0_res_q;
        e0_rd_d  = e0_rd_q;
        e0_wen_d = e0_wen_q;
        e1_res_d = e1_res_q;
        e1_rd_d  = e1_rd_q;
        e1_wen_d = e1_wen_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    e0_res_d = ex_result;
                    e0_rd_d  = ex_rd;
                    e0_wen_d = ex_wen;
                    state_d  = ONE;
                end
            end
            ONE: begin
                // Push with pop: head is replaced in place, no bubble.
                if (push) begin
                    if (pop) begin
                        e0_res_d = ex_result;
                        e0_rd_d  = ex_rd;
                        e0_wen_d = ex_wen;
                    end else begin
                        e1_res_d = ex_result;
                        e1_rd_d  = ex_rd;
                        e1_wen_d = ex_wen;
                        state_d  = FULL;
                    end
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    e0_res_d = e1_res_q;
                    e0_rd_d  = e1_rd_q;
                    e0_wen_d = e1_wen_q;
                    state_d  = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops incoming and held entries; payload regs are don't-care.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q  <= EMPTY;
            e0_res_q <= '0;
            e0_rd_q  <= '0;
            e0_wen_q <= 1'b0;
            e1_res_q <= '0;
            e1_rd_q  <= '0;
            e1_wen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            e0_res_q <= e0_res_d;
            e0_rd_q  <= e0_rd_d;
            e0_wen_q <= e0_wen_d;
            e1_res_q <= e1_res_d;
            e1_rd_q  <= e1_rd_d;
            e1_wen_q <= e1_wen_d;
        end
    end

`ifdef FRV_EX_WB_FWD_EN
    logic e0_fw, e1_fw;
    logic h0_rs1, h1_rs1, h0_rs2, h1_rs2;

    // An entry can forward only if it really writes a non-zero register.
    assign e0_fw = (state_q != EMPTY) & e0_wen_q & (e0_rd_q != '0);
    assign e1_fw = (state_q == FULL) & e1_wen_q & (e1_rd_q != '0);

    assign h0_rs1 = e0_fw & (e0_rd_q == hz_rs1);
    assign h1_rs1 = e1_fw & (e1_rd_q == hz_rs1);
    assign h0_rs2 = e0_fw & (e0_rd_q == hz_rs2);
    assign h1_rs2 = e1_fw & (e1_rd_q == hz_rs2);

    assign hz_rs1_hit = h0_rs1 | h1_rs1;
    assign hz_rs2_hit = h0_rs2 | h1_rs2;

    // E1 is younger, so it takes priority.
    assign hz_rs1_data = h1_rs1 ? e1_res_q : (h0_rs1 ? e0_res_q : '0);
    assign hz_rs2_data = h1_rs2 ? e1_res_q : (h0_rs2 ? e0_res_q : '0);
`endif

endmodule
